// File: rtl/control_multicycle_pkg.sv
// Shared core defines for the multicycle control: opcodes, control-field encodings,
// FSM state encoding and the opcode classifier used by the control and its decoder.
package control_multicycle_pkg;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,
        ALU_FUNCT  = 2'b10,
        ALU_BRANCH = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        SRC_A_RS1  = 2'b00,
        SRC_A_PC   = 2'b01,
        SRC_A_ZERO = 2'b10
    } src_a_e;

    typedef enum logic [1:0] {
        SRC_B_RS2 = 2'b00,
        SRC_B_IMM = 2'b01
    } src_b_e;

    typedef enum logic [1:0] {
        M2R_ALU  = 2'b00,
        M2R_LOAD = 2'b01,
        M2R_PC4  = 2'b10
    } m2r_e;

    typedef enum logic [1:0] {
        PC_SRC_PC4    = 2'b00,
        PC_SRC_ALU    = 2'b01,
        PC_SRC_BRANCH = 2'b10
    } pc_src_e;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JAL,
        CLS_JALR,
        CLS_LUI,
        CLS_AUIPC,
        CLS_OPIMM,
        CLS_OP,
        CLS_ILLEGAL
    } opc_class_e;

    typedef struct packed {
        logic    inst_mem_read_enable;
        logic    ir_write_enable;
        logic    branch_enable;
        logic    data_mem_read_enable;
        logic    data_mem_write_enable;
        logic    regfile_write_enable;
        logic    pc_write_enable;
        logic    instret;
        pc_src_e pc_src_sel;
        m2r_e    mem_to_reg_sel;
        alu_op_e alu_op;
        src_a_e  alu_sel_src_a;
        src_b_e  alu_sel_src_b;
    } ctrl_t;

    // The 32-bit word ops share the datapath sequencing of their 64-bit forms.
    function automatic opc_class_e classify(input logic [6:0] opc, input bit en32);
        opc_class_e cls;
        case (opc)
            OPC_LOAD:      cls = CLS_LOAD;
            OPC_STORE:     cls = CLS_STORE;
            OPC_BRANCH:    cls = CLS_BRANCH;
            OPC_JAL:       cls = CLS_JAL;
            OPC_JALR:      cls = CLS_JALR;
            OPC_LUI:       cls = CLS_LUI;
            OPC_AUIPC:     cls = CLS_AUIPC;
            OPC_OP_IMM:    cls = CLS_OPIMM;
            OPC_OP:        cls = CLS_OP;
            OPC_OP_IMM_32: cls = en32 ? CLS_OPIMM : CLS_ILLEGAL;
            OPC_OP_32:     cls = en32 ? CLS_OP : CLS_ILLEGAL;
            default:       cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/control_multicycle_if.sv
// Control <-> datapath bundle: opcode and memory handshakes in, control fields out.
// master = the control FSM, slave = the datapath side.
interface control_multicycle_if;

    logic [6:0] inst_opcode;
    logic       imem_ready;
    logic       dmem_ready;

    logic       inst_mem_read_enable;
    logic       ir_write_enable;
    logic       branch_enable;
    logic       data_mem_read_enable;
    logic       data_mem_write_enable;
    logic       regfile_write_enable;
    logic       pc_write_enable;
    logic [1:0] pc_src_sel;
    logic [1:0] mem_to_reg_sel;
    logic [1:0] alu_op;
    logic [1:0] alu_sel_src_a;
    logic [1:0] alu_sel_src_b;
    logic       instret;
    logic       illegal_inst;

    modport master (
        input  inst_opcode, imem_ready, dmem_ready,
        output inst_mem_read_enable, ir_write_enable, branch_enable,
               data_mem_read_enable, data_mem_write_enable, regfile_write_enable,
               pc_write_enable, pc_src_sel, mem_to_reg_sel, alu_op,
               alu_sel_src_a, alu_sel_src_b, instret, illegal_inst
    );

    modport slave (
        output inst_opcode, imem_ready, dmem_ready,
        input  inst_mem_read_enable, ir_write_enable, branch_enable,
               data_mem_read_enable, data_mem_write_enable, regfile_write_enable,
               pc_write_enable, pc_src_sel, mem_to_reg_sel, alu_op,
               alu_sel_src_a, alu_sel_src_b, instret, illegal_inst
    );

endinterface

// File: rtl/control_multicycle_ctrl_field_decode.sv
// Combinational map from (state, latched opcode, memory handshakes) to the control bundle.
// Only FETCH and MEM look at the handshakes; every other field is a pure state/opcode decode.
module ctrl_field_decode
    import control_multicycle_pkg::*;
#(
    parameter bit ENABLE_OP32 = 1'b1
) (
    input  state_t     i_state,
    input  logic [6:0] i_opcode,
    input  logic       i_imem_ready,
    input  logic       i_dmem_ready,
    output ctrl_t      o_ctrl
);

    opc_class_e w_cls;

    assign w_cls = classify(i_opcode, ENABLE_OP32);

    always_comb begin
        // NOTE: every field gets a default before the case so no path leaves a latch behind.
        o_ctrl = '0;
        case (i_state)
            ST_FETCH: begin
                o_ctrl.inst_mem_read_enable = 1'b1;
                o_ctrl.ir_write_enable      = i_imem_ready;
            end

            ST_EXEC: begin
                case (w_cls)
                    CLS_LOAD, CLS_STORE, CLS_JALR: begin
                        o_ctrl.alu_op        = ALU_ADD;
                        o_ctrl.alu_sel_src_a = SRC_A_RS1;
                        o_ctrl.alu_sel_src_b = SRC_B_IMM;
                    end
                    CLS_OPIMM: begin
                        o_ctrl.alu_op        = ALU_FUNCT;
                        o_ctrl.alu_sel_src_a = SRC_A_RS1;
                        o_ctrl.alu_sel_src_b = SRC_B_IMM;
                    end
                    CLS_OP: begin
                        o_ctrl.alu_op        = ALU_FUNCT;
                        o_ctrl.alu_sel_src_a = SRC_A_RS1;
                        o_ctrl.alu_sel_src_b = SRC_B_RS2;
                    end
                    CLS_AUIPC, CLS_JAL: begin
                        o_ctrl.alu_op        = ALU_ADD;
                        o_ctrl.alu_sel_src_a = SRC_A_PC;
                        o_ctrl.alu_sel_src_b = SRC_B_IMM;
                    end
                    CLS_LUI: begin
                        o_ctrl.alu_op        = ALU_ADD;
                        o_ctrl.alu_sel_src_a = SRC_A_ZERO;
                        o_ctrl.alu_sel_src_b = SRC_B_IMM;
                    end
                    CLS_BRANCH: begin
                        // Branches resolve and retire here; PC takes the target only if the compare says so.
                        o_ctrl.alu_op          = ALU_BRANCH;
                        o_ctrl.alu_sel_src_a   = SRC_A_RS1;
                        o_ctrl.alu_sel_src_b   = SRC_B_RS2;
                        o_ctrl.branch_enable   = 1'b1;
                        o_ctrl.pc_src_sel      = PC_SRC_BRANCH;
                        o_ctrl.pc_write_enable = 1'b1;
                        o_ctrl.instret         = 1'b1;
                    end
                    default: ;
                endcase
            end

            ST_MEM: begin
                if (w_cls == CLS_LOAD) begin
                    o_ctrl.data_mem_read_enable = 1'b1;
                end else if (w_cls == CLS_STORE) begin
                    o_ctrl.data_mem_write_enable = 1'b1;
                    if (i_dmem_ready) begin
                        o_ctrl.pc_write_enable = 1'b1;
                        o_ctrl.pc_src_sel      = PC_SRC_PC4;
                        o_ctrl.instret         = 1'b1;
                    end
                end
            end

            ST_WB: begin
                o_ctrl.regfile_write_enable = 1'b1;
                o_ctrl.pc_write_enable      = 1'b1;
                o_ctrl.instret              = 1'b1;
                case (w_cls)
                    CLS_LOAD: begin
                        o_ctrl.mem_to_reg_sel = M2R_LOAD;
                    end
                    CLS_JAL, CLS_JALR: begin
                        o_ctrl.mem_to_reg_sel = M2R_PC4;
                        o_ctrl.pc_src_sel     = PC_SRC_ALU;
                    end
                    default: ;
                endcase
            end

            default: ;
        endcase
    end

endmodule

// File: rtl/control_multicycle.sv
// Multicycle control FSM for the RV64I core: state register, opcode latch and sticky
// illegal flag; field decode is delegated to ctrl_field_decode.
module control_multicycle
    import control_multicycle_pkg::*;
#(
    parameter bit ENABLE_OP32 = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    control_multicycle_if.master bus
);

    state_t     r_state;
    state_t     w_next;
    logic [6:0] r_opcode;
    logic       r_illegal;
    opc_class_e w_dec_cls;
    opc_class_e w_cur_cls;
    ctrl_t      w_ctrl;
    ctrl_t      w_out;

    assign w_dec_cls = classify(bus.inst_opcode, ENABLE_OP32);
    assign w_cur_cls = classify(r_opcode, ENABLE_OP32);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_FETCH;
            r_opcode  <= '0;
            r_illegal <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            r_state <= w_next;
            if (r_state == ST_DECODE) begin
                r_opcode <= bus.inst_opcode;
                if (w_dec_cls == CLS_ILLEGAL) begin
                    r_illegal <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_FETCH: begin
                if (bus.imem_ready) w_next = ST_DECODE;
            end
            ST_DECODE: begin
                w_next = (w_dec_cls == CLS_ILLEGAL) ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                case (w_cur_cls)
                    CLS_BRANCH:          w_next = ST_FETCH;
                    CLS_LOAD, CLS_STORE: w_next = ST_MEM;
                    default:             w_next = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (bus.dmem_ready) begin
                    w_next = (w_cur_cls == CLS_LOAD) ? ST_WB : ST_FETCH;
                end
            end
            ST_WB:   w_next = ST_FETCH;
            ST_HALT: w_next = ST_HALT;
            default: w_next = ST_FETCH;
        endcase
    end

    ctrl_field_decode #(
        .ENABLE_OP32 (ENABLE_OP32)
    ) u_decode (
        .i_state      (r_state),
        .i_opcode     (r_opcode),
        .i_imem_ready (bus.imem_ready),
        .i_dmem_ready (bus.dmem_ready),
        .o_ctrl       (w_ctrl)
    );

    // Holding reset forces the bundle low at once, so FETCH's request only appears after release.
    assign w_out = rst_n ? w_ctrl : '0;

    assign bus.inst_mem_read_enable  = w_out.inst_mem_read_enable;
    assign bus.ir_write_enable       = w_out.ir_write_enable;
    assign bus.branch_enable         = w_out.branch_enable;
    assign bus.data_mem_read_enable  = w_out.data_mem_read_enable;
    assign bus.data_mem_write_enable = w_out.data_mem_write_enable;
    assign bus.regfile_write_enable  = w_out.regfile_write_enable;
    assign bus.pc_write_enable       = w_out.pc_write_enable;
    assign bus.pc_src_sel            = w_out.pc_src_sel;
    assign bus.mem_to_reg_sel        = w_out.mem_to_reg_sel;
    assign bus.alu_op                = w_out.alu_op;
    assign bus.alu_sel_src_a         = w_out.alu_sel_src_a;
    assign bus.alu_sel_src_b         = w_out.alu_sel_src_b;
    assign bus.instret               = w_out.instret;
    assign bus.illegal_inst          = r_illegal;

endmodule

// File: tb/tb_control_multicycle.sv
// Bench for control_multicycle: an RV64 build and an OP_32-disabled build share stimulus;
// a per-instruction schedule model supplies the expected bundle for every cycle.
module tb_control_multicycle;

    typedef struct packed {
        logic       imrd, irwe, bren, dmrd, dmwr, rfwe, pcwe, instret;
        logic [1:0] pcsrc, m2r, aluop, srca, srcb;
        logic       illegal;
    } vec_t;

    typedef struct packed {
        vec_t e1;
        vec_t e0;
    } pair_t;

    localparam logic [6:0] O_LOAD    = 7'b0000011;
    localparam logic [6:0] O_STORE   = 7'b0100011;
    localparam logic [6:0] O_BRANCH  = 7'b1100011;
    localparam logic [6:0] O_JAL     = 7'b1101111;
    localparam logic [6:0] O_JALR    = 7'b1100111;
    localparam logic [6:0] O_LUI     = 7'b0110111;
    localparam logic [6:0] O_AUIPC   = 7'b0010111;
    localparam logic [6:0] O_OPIMM   = 7'b0010011;
    localparam logic [6:0] O_OP      = 7'b0110011;
    localparam logic [6:0] O_OPIMM32 = 7'b0011011;
    localparam logic [6:0] O_OP32    = 7'b0111011;
    localparam logic [6:0] O_FENCE   = 7'b0001111;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    control_multicycle_if bus1 ();
    control_multicycle_if bus0 ();

    control_multicycle #(.ENABLE_OP32(1'b1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    control_multicycle #(.ENABLE_OP32(1'b0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

    vec_t got1, got0;
    assign got1 = {bus1.inst_mem_read_enable, bus1.ir_write_enable, bus1.branch_enable,
                   bus1.data_mem_read_enable, bus1.data_mem_write_enable, bus1.regfile_write_enable,
                   bus1.pc_write_enable, bus1.instret, bus1.pc_src_sel, bus1.mem_to_reg_sel,
                   bus1.alu_op, bus1.alu_sel_src_a, bus1.alu_sel_src_b, bus1.illegal_inst};
    assign got0 = {bus0.inst_mem_read_enable, bus0.ir_write_enable, bus0.branch_enable,
                   bus0.data_mem_read_enable, bus0.data_mem_write_enable, bus0.regfile_write_enable,
                   bus0.pc_write_enable, bus0.instret, bus0.pc_src_sel, bus0.mem_to_reg_sel,
                   bus0.alu_op, bus0.alu_sel_src_a, bus0.alu_sel_src_b, bus0.illegal_inst};

    int    n_cmp  = 0;
    int    n_bad  = 0;
    int    n_ret1 = 0;
    int    n_ret0 = 0;
    bit    h1     = 1'b0;
    bit    h0     = 1'b0;
    pair_t exp_q[$];

    task automatic check_vec(input string name, input vec_t got, input vec_t want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s @%0t: got %b want %b", name, $time, got, want);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d want %0d", name, $time, got, want);
        end
    endtask

    function automatic bit legal(input logic [6:0] opc, input bit en32);
        case (opc)
            O_LOAD, O_STORE, O_BRANCH, O_JAL, O_JALR, O_LUI, O_AUIPC, O_OPIMM, O_OP: return 1'b1;
            O_OPIMM32, O_OP32: return en32;
            default: return 1'b0;
        endcase
    endfunction

    function automatic vec_t halt_vec();
        vec_t v = '0;
        v.illegal = 1'b1;
        return v;
    endfunction

    // ALU setup and (for branches) resolution expected during the execute cycle.
    function automatic vec_t exec_vec(input logic [6:0] opc);
        vec_t v = '0;
        case (opc)
            O_LOAD, O_STORE, O_JALR: v.srcb = 2'b01;
            O_OPIMM, O_OPIMM32: begin v.aluop = 2'b10; v.srcb = 2'b01; end
            O_OP, O_OP32:       v.aluop = 2'b10;
            O_AUIPC, O_JAL:     begin v.srca = 2'b01; v.srcb = 2'b01; end
            O_LUI:              begin v.srca = 2'b10; v.srcb = 2'b01; end
            O_BRANCH: begin
                v.aluop = 2'b11; v.bren = 1'b1; v.pcsrc = 2'b10; v.pcwe = 1'b1; v.instret = 1'b1;
            end
            default: ;
        endcase
        return v;
    endfunction

    // One clock of stimulus; the expectation is queued for the negedge compare process.
    task automatic step(input logic rv, input logic imr, input logic dmr,
                        input logic [6:0] opc, input vec_t e);
        pair_t p;
        @(posedge clk);
        #1;
        rst_n = rv;
        bus1.imem_ready = imr; bus0.imem_ready = imr;
        bus1.dmem_ready = dmr; bus0.dmem_ready = dmr;
        bus1.inst_opcode = opc; bus0.inst_opcode = opc;
        if (!rv) begin
            h1 = 1'b0;
            h0 = 1'b0;
        end
        p.e1 = !rv ? '0 : (h1 ? halt_vec() : e);
        p.e0 = !rv ? '0 : (h0 ? halt_vec() : e);
        exp_q.push_back(p);
    endtask

    // Whole-instruction schedule: fw fetch stalls, mw data stalls; abort_mem stops inside MEM.
    task automatic run_inst(input logic [6:0] opc, input int fw, input int mw,
                            input bit abort_mem, output int n);
        vec_t e;
        bit   is_ld = (opc == O_LOAD);
        bit   is_st = (opc == O_STORE);
        n = 0;
        for (int i = 0; i < fw; i++) begin
            e = '0; e.imrd = 1'b1;
            step(1'b1, 1'b0, 1'b1, opc, e); n++;
        end
        e = '0; e.imrd = 1'b1; e.irwe = 1'b1;
        step(1'b1, 1'b1, 1'b1, opc, e); n++;
        e = '0;
        step(1'b1, 1'b1, 1'b1, opc, e); n++;
        if (!legal(opc, 1'b1)) h1 = 1'b1;
        if (!legal(opc, 1'b0)) h0 = 1'b1;
        if (!legal(opc, 1'b1)) return;
        step(1'b1, 1'b1, 1'b1, opc, exec_vec(opc)); n++;
        if (opc == O_BRANCH) return;
        if (is_ld || is_st) begin
            for (int i = 0; i < mw; i++) begin
                e = '0; e.dmrd = is_ld; e.dmwr = is_st;
                step(1'b1, 1'b1, 1'b0, opc, e); n++;
            end
            if (abort_mem) return;
            e = '0; e.dmrd = is_ld; e.dmwr = is_st;
            if (is_st) begin e.pcwe = 1'b1; e.instret = 1'b1; end
            step(1'b1, 1'b0, 1'b1, opc, e); n++;
            if (is_st) return;
        end
        e = '0; e.rfwe = 1'b1; e.pcwe = 1'b1; e.instret = 1'b1;
        if (is_ld) e.m2r = 2'b01;
        if (opc == O_JAL || opc == O_JALR) begin e.m2r = 2'b10; e.pcsrc = 2'b01; end
        step(1'b1, 1'b1, 1'b1, opc, e); n++;
    endtask

    always @(negedge clk) begin
        pair_t p;
        if (exp_q.size() > 0) begin
            p = exp_q.pop_front();
            check_vec("dut_rv64", got1, p.e1);
            check_vec("dut_no_op32", got0, p.e0);
            if (got1.instret) n_ret1++;
            if (got0.instret) n_ret0++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus1.imem_ready = 1'b0; bus0.imem_ready = 1'b0;
        bus1.dmem_ready = 1'b0; bus0.dmem_ready = 1'b0;
        bus1.inst_opcode = '0;  bus0.inst_opcode = '0;
        rst_n = 1'b0;

        // Reset with both handshakes high: everything must stay quiet.
        repeat (3) step(1'b0, 1'b1, 1'b1, 7'd0, '0);

        run_inst(O_OPIMM, 0, 0, 1'b0, n);  check_int("addi_cycles", n, 4);
        @(negedge clk); #1;
        check_int("addi_instret", n_ret1, 1);
        run_inst(O_LOAD, 0, 3, 1'b0, n);   check_int("lw_wait3_cycles", n, 8);
        run_inst(O_STORE, 0, 0, 1'b0, n);  check_int("sw_cycles", n, 4);
        run_inst(O_BRANCH, 0, 0, 1'b0, n); check_int("beq_cycles", n, 3);
        run_inst(O_JAL, 0, 0, 1'b0, n);    check_int("jal_cycles", n, 4);
        run_inst(O_JALR, 0, 0, 1'b0, n);
        run_inst(O_LUI, 0, 0, 1'b0, n);
        run_inst(O_AUIPC, 0, 0, 1'b0, n);
        run_inst(O_OP, 2, 0, 1'b0, n);     check_int("op_fetch_wait2_cycles", n, 6);

        // OP_32 retires on the RV64 build but halts the other one.
        run_inst(O_OP32, 0, 0, 1'b0, n);   check_int("op32_cycles", n, 4);
        run_inst(O_FENCE, 0, 0, 1'b0, n);  check_int("fence_cycles", n, 2);
        repeat (3) step(1'b1, 1'b1, 1'b1, O_LOAD, '0);
        repeat (2) step(1'b0, 1'b0, 1'b0, 7'd0, '0);
        run_inst(O_OPIMM, 0, 0, 1'b0, n);

        // Store interrupted by reset while the write request is outstanding.
        run_inst(O_STORE, 0, 2, 1'b1, n);  check_int("sw_abort_cycles", n, 5);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_vec("async_drop_rv64", got1, '0);
        check_vec("async_drop_no_op32", got0, '0);
        repeat (2) step(1'b0, 1'b0, 1'b1, 7'd0, '0);
        run_inst(O_OPIMM, 0, 0, 1'b0, n);

        @(negedge clk); #1;
        check_int("instret_total_rv64", n_ret1, 12);
        check_int("instret_total_no_op32", n_ret0, 11);
        check_int("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
